rheed_result_merger: RTL and testbench

// Collects the per-class CNN result streams (N_OUT lanes, one beat per lane per frame) behind the

---
 rtl/rheed_result_merger.sv | 259 +++++++++++++++++++++++++
 tb/tb_rheed_result_merger.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rheed_result_merger.sv
// ---------------------------------------------------------------------------
// rheed_result_merger
//
// Purpose:
//   Collects the per-class CNN result lanes for one frame. Each lane delivers
//   one beat per frame. The lanes are packed into a single tagged result word
//   {frame_idx, lane[N_OUT-1] .. lane[0]}. The word is pushed into a small
//   first-word-fall-through FIFO and leaves on one AXI-Stream master.
//
//   When the FIFO is full, the finished frame is handled in one of two ways:
//     DROP_ON_FULL = 0 : the frame waits in COMMIT. Lane ready stays low, which
//                        stalls the CNN.
//     DROP_ON_FULL = 1 : the frame is discarded and ovf_cnt is incremented.
//   A new ap_start during a partially collected frame discards that frame and
//   increments abort_cnt.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   ap_start         frame start pulse (same pulse as sent to the CNN)
//   s_axis_tvalid    per-lane valid                  [N_OUT]
//   s_axis_tready    per-lane ready                  [N_OUT]
//   s_axis_tdata     lane i at [i*DATA_W +: DATA_W]
//   m_axis_tvalid    result word valid
//   m_axis_tready    downstream ready
//   m_axis_tdata     {frame_idx, lane N_OUT-1 .. lane 0}
//   fifo_level       occupied FIFO entries
//   ovf_cnt          frames dropped on full FIFO (saturating)
//   abort_cnt        partial frames discarded by ap_start (saturating)
// ---------------------------------------------------------------------------
module rheed_result_merger #(
    parameter int N_OUT        = 5,
    parameter int DATA_W       = 8,
    parameter int IDX_W        = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ap_start,
    input  logic [N_OUT-1:0]                s_axis_tvalid,
    output logic [N_OUT-1:0]                s_axis_tready,
    input  logic [N_OUT*DATA_W-1:0]         s_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [IDX_W+N_OUT*DATA_W-1:0]   m_axis_tdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     ovf_cnt,
    output logic [15:0]                     abort_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = IDX_W + N_OUT * DATA_W;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT
    } state_t;

    // Frame collection state
    state_t                    r_state;
    state_t                    w_nextState;
    logic [N_OUT-1:0]          r_got;
    logic [N_OUT*DATA_W-1:0]   r_data;
    logic [IDX_W-1:0]          r_curIdx;
    logic [IDX_W-1:0]          r_idx;
    logic [15:0]               r_ovfCnt;
    logic [15:0]               r_abortCnt;

    // Result FIFO storage
    logic [WORD_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wrPtr;
    logic [PTR_W-1:0]          r_rdPtr;
    logic [LVL_W-1:0]          r_level;

    // Combinational control
    logic [N_OUT-1:0]          w_ready;
    logic [N_OUT-1:0]          w_accept;
    logic [N_OUT-1:0]          w_gotNext;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_start;
    logic                      w_abort;
    logic                      w_drop;
    logic                      w_clearGot;

    // A lane is ready only while collecting and only until it has delivered
    // its beat for this frame. w_gotNext includes captures on this edge, so
    // the FSM can move to COMMIT on the same edge as the last lane arrives.
    assign w_ready   = (r_state == ST_COLLECT) ? ~r_got : '0;
    assign w_accept  = s_axis_tvalid & w_ready;
    assign w_gotNext = r_got | w_accept;

    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = (r_level != '0) && m_axis_tready;

    assign s_axis_tready = w_ready;
    assign m_axis_tvalid = (r_level != '0);
    assign m_axis_tdata  = r_mem[r_rdPtr];
    assign fifo_level    = r_level;
    assign ovf_cnt       = r_ovfCnt;
    assign abort_cnt     = r_abortCnt;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode.
    // ap_start always wins: it restarts collection from any busy state. A
    // finished frame still sitting in COMMIT is discarded rather than written.
    // In COMMIT, a full FIFO can still take the word if it pops on the same
    // edge, because the pop frees the slot the push lands in.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_clearGot  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_start     = 1'b1;
                    w_nextState = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (ap_start) begin
                    w_start     = 1'b1;
                    w_abort     = |r_got;
                    w_nextState = ST_COLLECT;
                end else if (&w_gotNext) begin
                    w_nextState = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (ap_start) begin
                    w_start     = 1'b1;
                    w_abort     = |r_got;
                    w_nextState = ST_COLLECT;
                end else if (!w_full || w_pop) begin
                    w_push      = 1'b1;
                    w_clearGot  = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (DROP_ON_FULL != 0) begin
                    w_drop      = 1'b1;
                    w_clearGot  = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Lane bookkeeping: got[] tracks which lanes have delivered this frame.
    // A restart or the end of a frame clears got[]. Clearing got[] is enough
    // to discard stale lane data, because every lane must be captured again
    // before the next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_got <= '0;
        end else if (w_start || w_clearGot) begin
            r_got <= '0;
        end else begin
            r_got <= w_gotNext;
        end
    end

    // Lane data capture: each lane is stored on its own handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_accept[i]) begin
                    r_data[i*DATA_W +: DATA_W] <= s_axis_tdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Frame index: each start latches the running index as the tag for the
    // frame now being collected, then advances it (wrapping naturally).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_curIdx <= '0;
            r_idx    <= '0;
        end else if (w_start) begin
            r_curIdx <= r_idx;
            r_idx    <= r_idx + IDX_ONE;
        end
    end

    // Saturating event counters for dropped and aborted frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovfCnt   <= '0;
            r_abortCnt <= '0;
        end else begin
            if (w_drop && (r_ovfCnt != CNT_MAX)) begin
                r_ovfCnt <= r_ovfCnt + 16'd1;
            end
            if (w_abort && (r_abortCnt != CNT_MAX)) begin
                r_abortCnt <= r_abortCnt + 16'd1;
            end
        end
    end

    // FIFO storage. It is cleared on reset so that m_axis_tdata reads zero
    // straight out of reset, even though the output is taken from the storage
    // location at the read pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wrPtr] <= {r_curIdx, r_data};
        end
    end

    // FIFO pointers and occupancy. A push and a pop on the same edge leave
    // the level unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_rheed_result_merger.sv
// ---------------------------------------------------------------------------
// tb_rheed_result_merger
//
// Purpose:
//   Directed testbench for rheed_result_merger. It uses two instances that
//   share the same inputs:
//     dut0 : default build (16-bit index, stall on full FIFO)
//     dut1 : 2-bit index, drop on full FIFO, so index wrap is reachable
//   Inputs change and outputs are sampled 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_rheed_result_merger;

    logic        clk;
    logic        reset;
    logic        ap_start;
    logic [4:0]  sValid;
    logic [39:0] sData;
    logic        mReady;

    logic [4:0]  rdy0;
    logic        mValid0;
    logic [55:0] mData0;
    logic [2:0]  lvl0;
    logic [15:0] ovf0;
    logic [15:0] abort0;

    logic [4:0]  rdy1;
    logic        mValid1;
    logic [41:0] mData1;
    logic [2:0]  lvl1;
    logic [15:0] ovf1;
    logic [15:0] abort1;

    int checks;
    int errors;

    rheed_result_merger #(
        .N_OUT(5), .DATA_W(8), .IDX_W(16), .FIFO_DEPTH(4), .DROP_ON_FULL(0)
    ) dut0 (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .s_axis_tvalid(sValid), .s_axis_tready(rdy0), .s_axis_tdata(sData),
        .m_axis_tvalid(mValid0), .m_axis_tready(mReady), .m_axis_tdata(mData0),
        .fifo_level(lvl0), .ovf_cnt(ovf0), .abort_cnt(abort0)
    );

    rheed_result_merger #(
        .N_OUT(5), .DATA_W(8), .IDX_W(2), .FIFO_DEPTH(4), .DROP_ON_FULL(1)
    ) dut1 (
        .clk(clk), .reset(reset), .ap_start(ap_start),
        .s_axis_tvalid(sValid), .s_axis_tready(rdy1), .s_axis_tdata(sData),
        .m_axis_tvalid(mValid1), .m_axis_tready(mReady), .m_axis_tdata(mData1),
        .fifo_level(lvl1), .ovf_cnt(ovf1), .abort_cnt(abort1)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane data for frame f: lane i carries f*16 + i + 1
    function automatic logic [39:0] frameData(input int f);
        logic [39:0] d;
        for (int i = 0; i < 5; i++) begin
            d[i*8 +: 8] = 8'(f * 16 + i + 1);
        end
        return d;
    endfunction

    // Advance one clock edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs idle
    task automatic applyReset();
        reset    = 1'b1;
        ap_start = 1'b0;
        sValid   = '0;
        sData    = '0;
        mReady   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full frame: start, all lanes at once, commit edge, one spare idle cycle
    task automatic feedFrame(input int f);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        sValid   = 5'h1F;
        sData    = frameData(f);
        tick();
        sValid   = '0;
        tick();
        tick();
    endtask

    // Checks the state of both instances straight out of reset
    task automatic test_reset();
        applyReset();
        checks++; if (rdy0 !== 5'h00)    begin errors++; $display("[TB] FAIL reset_tready: got %h expected 00", rdy0); end
        checks++; if (mValid0 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", mValid0); end
        checks++; if (mData0 !== 56'h0)  begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", mData0); end
        checks++; if (lvl0 !== 3'd0)     begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", lvl0); end
        checks++; if (ovf0 !== 16'd0 || abort0 !== 16'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", ovf0, abort0); end
        checks++; if (mValid1 !== 1'b0 || lvl1 !== 3'd0) begin errors++; $display("[TB] FAIL reset_dut1: got %b/%0d expected 0/0", mValid1, lvl1); end
    endtask

    // Lanes arrive at cycles 2,3,3,5,7 after ap_start; checks word and latency
    task automatic test_basic_frame();
        applyReset();
        mReady   = 1'b1;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        sValid = 5'b00001; sData = 40'h00_00_00_00_11;
        tick();
        sValid = 5'b00110; sData = 40'h00_00_33_22_00;
        tick();
        checks++; if (rdy0 !== 5'b11000) begin errors++; $display("[TB] FAIL basic_partial_ready: got %b expected 11000", rdy0); end
        sValid = '0;
        tick();
        sValid = 5'b01000; sData = 40'h00_44_00_00_00;
        tick();
        sValid = '0;
        tick();
        sValid = 5'b10000; sData = 40'h55_00_00_00_00;
        tick();
        sValid = '0;
        checks++; if (mValid0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", mValid0); end
        tick();
        checks++; if (mValid0 !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", mValid0); end
        checks++; if (mData0 !== {16'd0, 40'h5544332211}) begin errors++; $display("[TB] FAIL basic_word: got %h expected %h", mData0, {16'd0, 40'h5544332211}); end
        checks++; if (lvl0 !== 3'd1) begin errors++; $display("[TB] FAIL basic_level1: got %0d expected 1", lvl0); end
        tick();
        checks++; if (lvl0 !== 3'd0 || mValid0 !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got level %0d valid %b expected 0/0", lvl0, mValid0); end
        mReady = 1'b0;
    endtask

    // Lane 2 is held valid after delivering; only its first beat may be kept
    task automatic test_lane_repeat();
        applyReset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        sValid = 5'b00100; sData = 40'h00_00_22_00_00;
        tick();
        checks++; if (rdy0 !== 5'b11011) begin errors++; $display("[TB] FAIL repeat_ready: got %b expected 11011", rdy0); end
        sValid = 5'b00111; sData = 40'h00_00_EE_02_01;
        tick();
        sValid = 5'b11100; sData = 40'h05_04_EE_00_00;
        tick();
        sValid = '0;
        tick();
        checks++; if (mData0 !== {16'd0, 40'h0504220201}) begin errors++; $display("[TB] FAIL repeat_word: got %h expected %h", mData0, {16'd0, 40'h0504220201}); end
    endtask

    // Five frames into a 4-deep FIFO with no downstream ready:
    // dut0 stalls the 5th frame, dut1 drops it
    task automatic test_full_policy();
        applyReset();
        for (int f = 0; f < 4; f++) begin
            feedFrame(f);
        end
        checks++; if (lvl0 !== 3'd4 || lvl1 !== 3'd4) begin errors++; $display("[TB] FAIL full_level: got %0d/%0d expected 4/4", lvl0, lvl1); end
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        sValid = 5'h1F; sData = frameData(4);
        checks++; if (rdy1 !== 5'h1F) begin errors++; $display("[TB] FAIL drop_lanes_ready: got %b expected 11111", rdy1); end
        tick();
        sValid = '0;
        checks++; if (rdy0 !== 5'h00) begin errors++; $display("[TB] FAIL stall_ready: got %b expected 00000", rdy0); end
        tick();
        checks++; if (ovf1 !== 16'd1 || lvl1 !== 3'd4) begin errors++; $display("[TB] FAIL drop_ovf: got ovf %0d level %0d expected 1/4", ovf1, lvl1); end
        tick();
        checks++; if (lvl0 !== 3'd4 || rdy0 !== 5'h00) begin errors++; $display("[TB] FAIL stall_hold: got level %0d ready %b expected 4/00000", lvl0, rdy0); end
        checks++; if (mData0 !== {16'd0, frameData(0)}) begin errors++; $display("[TB] FAIL stall_head: got %h expected %h", mData0, {16'd0, frameData(0)}); end
        mReady = 1'b1;
        tick();
        checks++; if (lvl0 !== 3'd4 || ovf0 !== 16'd0) begin errors++; $display("[TB] FAIL stall_release: got level %0d ovf %0d expected 4/0", lvl0, ovf0); end
        checks++; if (lvl1 !== 3'd3) begin errors++; $display("[TB] FAIL drop_pop: got %0d expected 3", lvl1); end
        for (int k = 1; k <= 4; k++) begin
            checks++; if (mData0 !== {16'(k), frameData(k)}) begin errors++; $display("[TB] FAIL stall_order%0d: got %h expected %h", k, mData0, {16'(k), frameData(k)}); end
            if (k < 4) begin
                checks++; if (mData1 !== {2'(k), frameData(k)}) begin errors++; $display("[TB] FAIL drop_order%0d: got %h expected %h", k, mData1, {2'(k), frameData(k)}); end
            end else begin
                checks++; if (mValid1 !== 1'b0) begin errors++; $display("[TB] FAIL drop_empty: got %b expected 0", mValid1); end
            end
            tick();
        end
        checks++; if (lvl0 !== 3'd0) begin errors++; $display("[TB] FAIL stall_drained: got %0d expected 0", lvl0); end
        mReady = 1'b0;
        feedFrame(5);
        checks++; if (mData0 !== {16'd5, frameData(5)}) begin errors++; $display("[TB] FAIL stall_next_tag: got %h expected %h", mData0, {16'd5, frameData(5)}); end
        checks++; if (mData1 !== {2'd1, frameData(5)}) begin errors++; $display("[TB] FAIL wrap_tag: got %h expected %h", mData1, {2'd1, frameData(5)}); end
    endtask

    // ap_start after 3 of 5 lanes aborts; the next frame must need all 5 lanes again
    task automatic test_abort();
        applyReset();
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        sValid = 5'b00111; sData = 40'h00_00_CC_BB_AA;
        tick();
        sValid = '0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        checks++; if (abort0 !== 16'd1) begin errors++; $display("[TB] FAIL abort_count: got %0d expected 1", abort0); end
        checks++; if (rdy0 !== 5'h1F) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 11111", rdy0); end
        sValid = 5'b11000; sData = 40'h45_34_00_00_00;
        tick();
        checks++; if (rdy0 !== 5'b00111) begin errors++; $display("[TB] FAIL abort_stale: got %b expected 00111", rdy0); end
        sValid = 5'b00111; sData = 40'h00_00_32_21_10;
        tick();
        sValid = '0;
        tick();
        checks++; if (lvl0 !== 3'd1 || mData0 !== {16'd1, 40'h4534322110}) begin errors++; $display("[TB] FAIL abort_word: got level %0d word %h expected 1 %h", lvl0, mData0, {16'd1, 40'h4534322110}); end
    endtask

    // Restart with nothing collected is not an abort; ap_start beats a commit
    task automatic test_restart_priority();
        applyReset();
        ap_start = 1'b1;
        tick();
        tick();
        ap_start = 1'b0;
        checks++; if (abort0 !== 16'd0) begin errors++; $display("[TB] FAIL restart_no_abort: got %0d expected 0", abort0); end
        sValid = 5'h1F; sData = frameData(7);
        tick();
        sValid   = '0;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        checks++; if (lvl0 !== 3'd0 || abort0 !== 16'd1) begin errors++; $display("[TB] FAIL commit_preempt: got level %0d abort %0d expected 0/1", lvl0, abort0); end
        sValid = 5'h1F; sData = frameData(8);
        tick();
        sValid = '0;
        tick();
        checks++; if (mData0 !== {16'd2, frameData(8)}) begin errors++; $display("[TB] FAIL restart_tag: got %h expected %h", mData0, {16'd2, frameData(8)}); end
    endtask

    // Asynchronous reset mid-COLLECT with two words buffered
    task automatic test_reset_midframe();
        applyReset();
        feedFrame(1);
        feedFrame(2);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        sValid = 5'b00011; sData = frameData(3);
        tick();
        sValid = '0;
        checks++; if (lvl0 !== 3'd2) begin errors++; $display("[TB] FAIL midreset_pre_level: got %0d expected 2", lvl0); end
        reset = 1'b1;
        #2;
        checks++; if (lvl0 !== 3'd0 || mValid0 !== 1'b0 || mData0 !== 56'h0) begin errors++; $display("[TB] FAIL midreset_async: got level %0d valid %b word %h expected 0/0/0", lvl0, mValid0, mData0); end
        checks++; if (rdy0 !== 5'h00 || abort0 !== 16'd0) begin errors++; $display("[TB] FAIL midreset_ctrl: got ready %b abort %0d expected 00000/0", rdy0, abort0); end
        tick();
        reset = 1'b0;
        feedFrame(4);
        checks++; if (lvl0 !== 3'd1 || mData0 !== {16'd0, frameData(4)}) begin errors++; $display("[TB] FAIL midreset_restart: got level %0d word %h expected 1 %h", lvl0, mData0, {16'd0, frameData(4)}); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        ap_start = 1'b0;
        sValid   = '0;
        sData    = '0;
        mReady   = 1'b0;
        test_reset();
        test_basic_frame();
        test_lane_repeat();
        test_full_policy();
        test_abort();
        test_restart_priority();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
